div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 133 +++++++++++++
 tb/tb_div_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit divider for DIV (signed) / DIVU (unsigned).
// One restoring radix-2 step per clock. The result is written to the
// HI/LO register as {remainder, quotient}.
//
// Ports:
//   clk           - clock, all state changes on the rising edge
//   rst           - synchronous active-high reset
//   start         - DIV/DIVU issued from execute (accepted only in IDLE)
//   flag_unsigned - 1 = DIVU, 0 = DIV (two's complement)
//   dividend      - rs operand
//   divisor       - rt operand
//   cancel        - pipeline flush; aborts the operation, suppresses done
//   stall         - combinational pipeline hold request
//   busy          - operation in progress (state != IDLE)
//   done          - one-cycle result-valid pulse
//   we_hilo       - HI/LO write enable, identical to done
//   reg_hilo_o    - registered {HI = remainder, LO = quotient}
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flag_unsigned,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        cancel,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic        we_hilo,
    output logic [63:0] reg_hilo_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic        op_unsigned;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_b;
    // Partial remainder in the upper half, dividend bits shifting out of
    // the lower half while quotient bits shift in behind them.
    logic [63:0] prem;

    logic        accept;
    logic [32:0] trial_top;
    logic        no_borrow;
    logic [31:0] trial_diff;
    logic [63:0] prem_step;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return v[31] ? -v : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    assign accept = (state == IDLE) && start && !cancel;

    // One restoring step. The shifted remainder can reach 33 bits, so the
    // trial compare uses prem[63:31]; the difference itself always fits in
    // 32 bits because it is smaller than the divisor magnitude.
    always_comb begin
        trial_top  = prem[63:31];
        no_borrow  = (trial_top >= {1'b0, mag_b});
        trial_diff = trial_top[31:0] - mag_b;
        prem_step  = no_borrow ? {trial_diff, prem[30:0], 1'b1}
                               : {prem[62:0], 1'b0};
        // Sign fix-up on the final step's result; 0x80000000 / -1 wraps
        // naturally because negating 0x80000000 yields itself.
        quo_fix    = neg_if(!op_unsigned && (sign_a ^ sign_b), prem_step[31:0]);
        rem_fix    = neg_if(!op_unsigned && sign_a, prem_step[63:32]);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = (divisor == 32'd0) ? DONE : CALC;
            CALC: if (cnt == 6'd31) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cancel) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 6'd0;
            reg_hilo_o <= 64'h0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= 6'd0;
                        if (divisor == 32'd0)
                            reg_hilo_o <= {dividend, 32'hFFFF_FFFF};
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31 && !cancel)
                        reg_hilo_o <= {rem_fix, quo_fix};
                end
                default: ;
            endcase
        end
    end

    // Operand/datapath registers carry no reset; they are always loaded
    // when an operation is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_unsigned <= flag_unsigned;
            sign_a      <= !flag_unsigned && dividend[31];
            sign_b      <= !flag_unsigned && divisor[31];
            mag_b       <= flag_unsigned ? divisor : abs32(divisor);
            prem        <= {32'h0, flag_unsigned ? dividend : abs32(dividend)};
        end else if (state == CALC) begin
            prem <= prem_step;
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE) && !cancel;
    assign we_hilo = done;
    assign stall   = !rst && (accept || (state == CALC));

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flag_unsigned;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        stall;
    logic        busy;
    logic        done;
    logic        we_hilo;
    logic [63:0] reg_hilo_o;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    logic [63:0] sb_q[$];

    div_unit dut (
        .clk(clk), .rst(rst), .start(start), .flag_unsigned(flag_unsigned),
        .dividend(dividend), .divisor(divisor), .cancel(cancel),
        .stall(stall), .busy(busy), .done(done), .we_hilo(we_hilo),
        .reg_hilo_o(reg_hilo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic u, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (u) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    // Scoreboard: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            check("we_hilo_eq_done", {63'h0, we_hilo}, 64'h1);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'h1, 64'h0);
            end else begin
                check("hilo_result", reg_hilo_o, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start in the current cycle (cycle 0); returns in cycle 1.
    task automatic issue(input logic u, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [63:0] exp);
        start = 1'b1;
        flag_unsigned = u;
        dividend = a;
        divisor = b;
        #1;
        check("stall_on_issue", {63'h0, stall}, 64'h1);
        if (push) sb_q.push_back(exp);
        tick();
        start = 1'b0;
    endtask

    // Called in cycle 1; waits for done with a bounded budget.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        while (!done && lat < 60) begin
            tick();
            lat++;
        end
        check({tag, "_done_seen"}, {63'h0, done}, 64'h1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic run(input string tag, input logic u, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
        issue(u, a, b, 1'b1, exp);
        wait_done(tag, (b == 32'd0) ? 1 : 33);
        tick();
    endtask

    initial begin
        int bad;
        int d0;
        logic [63:0] prev;
        logic        u;
        logic [31:0] a, b;

        rst = 1'b1; start = 1'b1; cancel = 1'b0;
        flag_unsigned = 1'b1; dividend = 32'd5; divisor = 32'd1;
        #1;
        check("stall_in_reset", {63'h0, stall}, 64'h0);
        tick();
        tick();
        check("stall_in_reset2", {63'h0, stall}, 64'h0);
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {62'h0, done, we_hilo}, 64'h0);
        check("reset_hilo", reg_hilo_o, 64'h0);
        rst = 1'b0; start = 1'b0;
        tick();

        // DIVU 100/7 with cycle-accurate busy/stall/done profile
        issue(1'b1, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            if (!(busy && stall && !done && !we_hilo)) bad++;
            tick();
        end
        check("divu_calc_profile", 64'(bad), 64'h0);
        check("divu_done_c33", {62'h0, done, we_hilo}, 64'h3);
        check("divu_stall_done", {63'h0, stall}, 64'h0);
        tick();
        check("divu_idle_c34", {62'h0, done, busy}, 64'h0);
        check("divu_hilo_hold", reg_hilo_o, {32'd2, 32'd14});

        run("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run("div_7_m2", 1'b0, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
        run("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        run("divu_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF});
        run("divu_max_max", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'h1, 32'h1});
        run("div0_u", 1'b1, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF});
        run("div0_s", 1'b0, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});

        // Cancel in cycle 10 of CALC, then a new start in cycle 11
        prev = reg_hilo_o;
        d0 = n_done;
        issue(1'b1, 32'd1000, 32'd3, 1'b0, 64'h0);
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_idle", {62'h0, busy, done}, 64'h0);
        check("cancel_hilo_kept", reg_hilo_o, prev);
        check("cancel_no_done", 64'(n_done - d0), 64'h0);
        issue(1'b0, 32'hFFFF_FC18, 32'd3, 1'b1, model(1'b0, 32'hFFFF_FC18, 32'd3));
        wait_done("after_cancel", 33);
        tick();

        // Reset in cycle 20 of CALC
        issue(1'b1, 32'd77, 32'd5, 1'b0, 64'h0);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_outputs", {61'h0, busy, done, we_hilo}, 64'h0);
        check("rst_mid_stall", {63'h0, stall}, 64'h0);
        check("rst_mid_hilo", reg_hilo_o, 64'h0);
        d0 = n_done;
        repeat (40) tick();
        check("rst_mid_no_done", 64'(n_done - d0), 64'h0);

        // start held high while busy: exactly one done
        d0 = n_done;
        issue(1'b1, 32'd500, 32'd9, 1'b1, {32'd5, 32'd55});
        start = 1'b1;
        wait_done("held_start", 33);
        start = 1'b0;
        repeat (40) tick();
        check("held_start_one_done", 64'(n_done - d0), 64'h1);

        // Random mix against the reference model
        for (int i = 0; i < 8; i++) begin
            u = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            if (i == 5) a = 32'h8000_0000;
            run("rand", u, a, b, model(u, a, b));
        end

        check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
